// File: rtl/issue_dispatch_unit_pkg.sv
// Shared types for the dual-issue dispatch stage: class encodings,
// the per-instruction issue field bundle and the pairing FSM states.
package issue_dispatch_unit_pkg;

    localparam logic [1:0] CLS_ALU    = 2'b00;
    localparam logic [1:0] CLS_BRANCH = 2'b01;
    localparam logic [1:0] CLS_MEM    = 2'b10;

    typedef enum logic {
        ACCEPT  = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Payload is carried beside this struct so its width can stay a module parameter
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
        logic [2:0] load_type;
        logic [1:0] store_type;
    } issue_slot_t;

endpackage

// File: rtl/issue_dispatch_unit_issue_steer.sv
// Pure combinational steering: decides whether a pair must be split and
// which pipe (Branch or Memory) each issuing slot lands in.
module issue_steer
    import issue_dispatch_unit_pkg::*;
(
    input  logic [1:0] valid,
    input  logic [1:0] cls0,
    input  logic [1:0] cls1,
    input  logic       raw,
    output logic       split,
    output logic       issue0,
    output logic       issue1,
    output logic       slot0_mem,
    output logic       slot1_mem
);
    logic both;
    logic mem0;
    logic mem1;
    logic br0;
    logic br1;
    logic pair_mem0;

    assign both = valid[0] & valid[1];
    assign mem0 = (cls0 == CLS_MEM);
    assign mem1 = (cls1 == CLS_MEM);
    assign br0  = (cls0 == CLS_BRANCH);
    assign br1  = (cls1 == CLS_BRANCH);

    assign split  = both & ((mem0 & mem1) | (br0 & br1) | raw);
    assign issue0 = valid[0];
    assign issue1 = valid[1] & ~split;

    // Paired: slot0 goes to Memory if it is MEM, or if it is ALU (incl. reserved) and slot1 wants Branch
    assign pair_mem0 = mem0 | (~br0 & br1);
    assign slot0_mem = (both & ~split) ? pair_mem0 : mem0;
    assign slot1_mem = both ? ~pair_mem0 : mem1;

endmodule

// File: rtl/issue_dispatch_unit.sv
// Issue stage: steers a decoded instruction pair into the Branch and Memory
// issue registers, splitting conflicting or dependent pairs over two cycles.
module issue_dispatch_unit
    import issue_dispatch_unit_pkg::*;
#(
    parameter int PAYLOAD_W = 64,
    parameter int SEQ_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                Dec_Valid,
    input  logic [1:0][1:0]           Dec_Class,
    input  logic [1:0][4:0]           Dec_rs1,
    input  logic [1:0][4:0]           Dec_rs2,
    input  logic [1:0][4:0]           Dec_rd,
    input  logic [1:0]                Dec_RF_Write_en,
    input  logic [1:0][2:0]           Dec_Load_Type,
    input  logic [1:0][1:0]           Dec_Store_Type,
    input  logic [1:0][PAYLOAD_W-1:0] Dec_Payload,
    output logic                      Dec_Ready,
    input  logic                      Stall_Issue_Branch_Pipeline,
    input  logic                      Stall_Issue_Memory_Pipeline,
    input  logic                      Flush_Dec,
    output logic                      Br_Valid,
    output logic                      Mem_Valid,
    output logic [4:0]                rs1_Issue_Branch_Pipeline,
    output logic [4:0]                rs2_Issue_Branch_Pipeline,
    output logic [4:0]                rd_Issue_Branch_Pipeline,
    output logic [4:0]                rs1_Issue_Memory_Pipeline,
    output logic [4:0]                rs2_Issue_Memory_Pipeline,
    output logic [4:0]                rd_Issue_Memory_Pipeline,
    output logic                      Br_RF_Write_en,
    output logic                      Mem_RF_Write_en,
    output logic [1:0][2:0]           Load_Type_Issue,
    output logic [1:0][1:0]           Store_Type_Issue,
    output logic [PAYLOAD_W-1:0]      Br_Payload,
    output logic [PAYLOAD_W-1:0]      Mem_Payload,
    output logic [SEQ_W-1:0]          Br_Seq,
    output logic [SEQ_W-1:0]          Mem_Seq,
    output logic                      Mem_Older
);
    state_t                 state;
    state_t                 state_nxt;
    logic                   hold;
    logic                   in_pend;

    issue_slot_t            dec_slot0;
    issue_slot_t            dec_slot1;
    logic                   raw;

    issue_slot_t            pend_slot;
    logic [PAYLOAD_W-1:0]   pend_pl;
    logic [1:0]             pend_cls;

    logic [1:0]             st_valid;
    logic [1:0]             st_cls0;
    logic                   st_raw;
    issue_slot_t            src0;
    logic [PAYLOAD_W-1:0]   src0_pl;
    logic                   split;
    logic                   issue0;
    logic                   issue1;
    logic                   slot0_mem;
    logic                   slot1_mem;

    logic [SEQ_W-1:0]       seq_cnt;
    logic [SEQ_W-1:0]       seq1;

    issue_slot_t            br_slot_p0;
    issue_slot_t            mem_slot_p0;
    logic [PAYLOAD_W-1:0]   br_pl_p0;
    logic [PAYLOAD_W-1:0]   mem_pl_p0;
    logic [SEQ_W-1:0]       br_seq_p0;
    logic [SEQ_W-1:0]       mem_seq_p0;
    logic                   br_vld_p0;
    logic                   mem_vld_p0;
    logic                   mem_older_p0;

    issue_slot_t            br_slot_p1;
    issue_slot_t            mem_slot_p1;
    logic [PAYLOAD_W-1:0]   br_pl_p1;
    logic [PAYLOAD_W-1:0]   mem_pl_p1;
    logic [SEQ_W-1:0]       br_seq_p1;
    logic [SEQ_W-1:0]       mem_seq_p1;
    logic                   br_vld_p1;
    logic                   mem_vld_p1;
    logic                   mem_older_p1;

    assign hold      = Stall_Issue_Branch_Pipeline | Stall_Issue_Memory_Pipeline;
    assign in_pend   = (state == PENDING);
    assign Dec_Ready = (state == ACCEPT) & ~hold & ~Flush_Dec & ~rst;

    assign dec_slot0 = '{rs1: Dec_rs1[0], rs2: Dec_rs2[0], rd: Dec_rd[0], we: Dec_RF_Write_en[0],
                         load_type: Dec_Load_Type[0], store_type: Dec_Store_Type[0]};
    assign dec_slot1 = '{rs1: Dec_rs1[1], rs2: Dec_rs2[1], rd: Dec_rd[1], we: Dec_RF_Write_en[1],
                         load_type: Dec_Load_Type[1], store_type: Dec_Store_Type[1]};

    assign raw = dec_slot0.we & (dec_slot0.rd != 5'd0) &
                 ((dec_slot1.rs1 == dec_slot0.rd) | (dec_slot1.rs2 == dec_slot0.rd));

    // While pending, the latched instruction is presented to the steer as a lone slot0
    assign st_valid = in_pend ? 2'b01 : Dec_Valid;
    assign st_cls0  = in_pend ? pend_cls : Dec_Class[0];
    assign st_raw   = ~in_pend & raw;
    assign src0     = in_pend ? pend_slot : dec_slot0;
    assign src0_pl  = in_pend ? pend_pl : Dec_Payload[0];

    issue_steer u_steer (
        .valid     (st_valid),
        .cls0      (st_cls0),
        .cls1      (Dec_Class[1]),
        .raw       (st_raw),
        .split     (split),
        .issue0    (issue0),
        .issue1    (issue1),
        .slot0_mem (slot0_mem),
        .slot1_mem (slot1_mem)
    );

    assign seq1 = seq_cnt + SEQ_W'(issue0);

    always_comb begin
        br_vld_p0    = 1'b0;
        mem_vld_p0   = 1'b0;
        br_slot_p0   = '0;
        mem_slot_p0  = '0;
        br_pl_p0     = '0;
        mem_pl_p0    = '0;
        br_seq_p0    = '0;
        mem_seq_p0   = '0;
        if (issue0) begin
            if (slot0_mem) begin
                mem_vld_p0  = 1'b1;
                mem_slot_p0 = src0;
                mem_pl_p0   = src0_pl;
                mem_seq_p0  = seq_cnt;
            end else begin
                br_vld_p0   = 1'b1;
                br_slot_p0  = src0;
                br_pl_p0    = src0_pl;
                br_seq_p0   = seq_cnt;
            end
        end
        if (issue1) begin
            if (slot1_mem) begin
                mem_vld_p0  = 1'b1;
                mem_slot_p0 = dec_slot1;
                mem_pl_p0   = Dec_Payload[1];
                mem_seq_p0  = seq1;
            end else begin
                br_vld_p0   = 1'b1;
                br_slot_p0  = dec_slot1;
                br_pl_p0    = Dec_Payload[1];
                br_seq_p0   = seq1;
            end
        end
        mem_older_p0 = issue0 & issue1 & slot0_mem;
    end

    always_comb begin
        state_nxt = state;
        if (Flush_Dec) begin
            state_nxt = ACCEPT;
        end else if (!hold) begin
            case (state)
                ACCEPT:  state_nxt = split ? PENDING : ACCEPT;
                PENDING: state_nxt = ACCEPT;
                default: state_nxt = ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCEPT;
        else     state <= state_nxt;
    end

    // ---- issue register stage (p0 -> p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            br_vld_p1    <= 1'b0;
            mem_vld_p1   <= 1'b0;
            br_slot_p1   <= '0;
            mem_slot_p1  <= '0;
            br_pl_p1     <= '0;
            mem_pl_p1    <= '0;
            br_seq_p1    <= '0;
            mem_seq_p1   <= '0;
            mem_older_p1 <= 1'b0;
            seq_cnt      <= '0;
            pend_slot    <= '0;
            pend_pl      <= '0;
            pend_cls     <= '0;
        end else if (Flush_Dec) begin
            br_vld_p1    <= 1'b0;
            mem_vld_p1   <= 1'b0;
            br_slot_p1   <= '0;
            mem_slot_p1  <= '0;
            br_pl_p1     <= '0;
            mem_pl_p1    <= '0;
            br_seq_p1    <= '0;
            mem_seq_p1   <= '0;
            mem_older_p1 <= 1'b0;
            pend_slot    <= '0;
            pend_pl      <= '0;
            pend_cls     <= '0;
        end else if (!hold) begin
            br_vld_p1    <= br_vld_p0;
            mem_vld_p1   <= mem_vld_p0;
            br_slot_p1   <= br_slot_p0;
            mem_slot_p1  <= mem_slot_p0;
            br_pl_p1     <= br_pl_p0;
            mem_pl_p1    <= mem_pl_p0;
            br_seq_p1    <= br_seq_p0;
            mem_seq_p1   <= mem_seq_p0;
            mem_older_p1 <= mem_older_p0;
            seq_cnt      <= seq1 + SEQ_W'(issue1);
            if (!in_pend && split) begin
                pend_slot <= dec_slot1;
                pend_pl   <= Dec_Payload[1];
                pend_cls  <= Dec_Class[1];
            end
        end
    end

    assign Br_Valid                  = br_vld_p1;
    assign Mem_Valid                 = mem_vld_p1;
    assign rs1_Issue_Branch_Pipeline = br_slot_p1.rs1;
    assign rs2_Issue_Branch_Pipeline = br_slot_p1.rs2;
    assign rd_Issue_Branch_Pipeline  = br_slot_p1.rd;
    assign rs1_Issue_Memory_Pipeline = mem_slot_p1.rs1;
    assign rs2_Issue_Memory_Pipeline = mem_slot_p1.rs2;
    assign rd_Issue_Memory_Pipeline  = mem_slot_p1.rd;
    assign Br_RF_Write_en            = br_slot_p1.we;
    assign Mem_RF_Write_en           = mem_slot_p1.we;
    assign Load_Type_Issue[0]        = br_slot_p1.load_type;
    assign Load_Type_Issue[1]        = mem_slot_p1.load_type;
    assign Store_Type_Issue[0]       = br_slot_p1.store_type;
    assign Store_Type_Issue[1]       = mem_slot_p1.store_type;
    assign Br_Payload                = br_pl_p1;
    assign Mem_Payload               = mem_pl_p1;
    assign Br_Seq                    = br_seq_p1;
    assign Mem_Seq                   = mem_seq_p1;
    assign Mem_Older                 = mem_older_p1;

endmodule

// File: tb/tb_issue_dispatch_unit.sv
// Scoreboard bench for issue_dispatch_unit: directed pairs push expected
// issue-register snapshots; a negedge monitor pops and compares them.
module tb_issue_dispatch_unit;
    import issue_dispatch_unit_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       Dec_Valid;
    logic [1:0][1:0]  Dec_Class;
    logic [1:0][4:0]  Dec_rs1, Dec_rs2, Dec_rd;
    logic [1:0]       Dec_RF_Write_en;
    logic [1:0][2:0]  Dec_Load_Type;
    logic [1:0][1:0]  Dec_Store_Type;
    logic [1:0][63:0] Dec_Payload;
    logic             Dec_Ready;
    logic             Stall_Issue_Branch_Pipeline, Stall_Issue_Memory_Pipeline, Flush_Dec;
    logic             Br_Valid, Mem_Valid;
    logic [4:0]       rs1_Issue_Branch_Pipeline, rs2_Issue_Branch_Pipeline, rd_Issue_Branch_Pipeline;
    logic [4:0]       rs1_Issue_Memory_Pipeline, rs2_Issue_Memory_Pipeline, rd_Issue_Memory_Pipeline;
    logic             Br_RF_Write_en, Mem_RF_Write_en;
    logic [1:0][2:0]  Load_Type_Issue;
    logic [1:0][1:0]  Store_Type_Issue;
    logic [63:0]      Br_Payload, Mem_Payload;
    logic [7:0]       Br_Seq, Mem_Seq;
    logic             Mem_Older;

    always #5 clk = ~clk;

    issue_dispatch_unit #(.PAYLOAD_W(64), .SEQ_W(8)) dut (
        .clk(clk), .rst(rst),
        .Dec_Valid(Dec_Valid), .Dec_Class(Dec_Class),
        .Dec_rs1(Dec_rs1), .Dec_rs2(Dec_rs2), .Dec_rd(Dec_rd),
        .Dec_RF_Write_en(Dec_RF_Write_en), .Dec_Load_Type(Dec_Load_Type),
        .Dec_Store_Type(Dec_Store_Type), .Dec_Payload(Dec_Payload),
        .Dec_Ready(Dec_Ready),
        .Stall_Issue_Branch_Pipeline(Stall_Issue_Branch_Pipeline),
        .Stall_Issue_Memory_Pipeline(Stall_Issue_Memory_Pipeline),
        .Flush_Dec(Flush_Dec),
        .Br_Valid(Br_Valid), .Mem_Valid(Mem_Valid),
        .rs1_Issue_Branch_Pipeline(rs1_Issue_Branch_Pipeline),
        .rs2_Issue_Branch_Pipeline(rs2_Issue_Branch_Pipeline),
        .rd_Issue_Branch_Pipeline(rd_Issue_Branch_Pipeline),
        .rs1_Issue_Memory_Pipeline(rs1_Issue_Memory_Pipeline),
        .rs2_Issue_Memory_Pipeline(rs2_Issue_Memory_Pipeline),
        .rd_Issue_Memory_Pipeline(rd_Issue_Memory_Pipeline),
        .Br_RF_Write_en(Br_RF_Write_en), .Mem_RF_Write_en(Mem_RF_Write_en),
        .Load_Type_Issue(Load_Type_Issue), .Store_Type_Issue(Store_Type_Issue),
        .Br_Payload(Br_Payload), .Mem_Payload(Mem_Payload),
        .Br_Seq(Br_Seq), .Mem_Seq(Mem_Seq), .Mem_Older(Mem_Older)
    );

    typedef struct packed {
        logic [1:0]  cls;
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [63:0] pl;
    } ins_t;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [63:0] pl;
        logic [7:0]  seq;
    } pipe_t;

    typedef struct packed {
        pipe_t br;
        pipe_t mem;
        logic  older;
    } exp_t;

    typedef struct {
        exp_t  e;
        string name;
    } sb_t;

    sb_t        sbq[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] s;
    ins_t       nil = '0;

    function automatic ins_t mk(input logic [1:0] c, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rd, input logic we, input logic [2:0] lt,
                                input logic [1:0] st, input logic [63:0] pl);
        ins_t i;
        i.cls = c; i.rs1 = r1; i.rs2 = r2; i.rd = rd; i.we = we; i.lt = lt; i.st = st; i.pl = pl;
        return i;
    endfunction

    function automatic pipe_t P(input ins_t i, input logic [7:0] sq);
        pipe_t p;
        p.v = 1'b1; p.rs1 = i.rs1; p.rs2 = i.rs2; p.rd = i.rd; p.we = i.we;
        p.lt = i.lt; p.st = i.st; p.pl = i.pl; p.seq = sq;
        return p;
    endfunction

    function automatic exp_t E(input pipe_t b, input pipe_t m, input logic o);
        exp_t e;
        e.br = b; e.mem = m; e.older = o;
        return e;
    endfunction

    task automatic drive(input ins_t i0, input logic v0, input ins_t i1, input logic v1);
        Dec_Valid = {v1, v0};
        Dec_Class[0] = i0.cls;      Dec_Class[1] = i1.cls;
        Dec_rs1[0] = i0.rs1;        Dec_rs1[1] = i1.rs1;
        Dec_rs2[0] = i0.rs2;        Dec_rs2[1] = i1.rs2;
        Dec_rd[0] = i0.rd;          Dec_rd[1] = i1.rd;
        Dec_RF_Write_en = {i1.we, i0.we};
        Dec_Load_Type[0] = i0.lt;   Dec_Load_Type[1] = i1.lt;
        Dec_Store_Type[0] = i0.st;  Dec_Store_Type[1] = i1.st;
        Dec_Payload[0] = i0.pl;     Dec_Payload[1] = i1.pl;
    endtask

    // One cycle: check Dec_Ready before the edge, then queue the expected issue registers
    task automatic step(input string name, input exp_t e, input logic rdy);
        sb_t t;
        #1;
        checks++;
        if (Dec_Ready !== rdy) begin
            errors++;
            $display("FAIL %s Dec_Ready: got %b want %b", name, Dec_Ready, rdy);
        end
        @(posedge clk);
        #1;
        t.e = e;
        t.name = name;
        sbq.push_back(t);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            sb_t  t;
            exp_t a;
            t = sbq.pop_front();
            a.br  = '{Br_Valid, rs1_Issue_Branch_Pipeline, rs2_Issue_Branch_Pipeline,
                      rd_Issue_Branch_Pipeline, Br_RF_Write_en, Load_Type_Issue[0],
                      Store_Type_Issue[0], Br_Payload, Br_Seq};
            a.mem = '{Mem_Valid, rs1_Issue_Memory_Pipeline, rs2_Issue_Memory_Pipeline,
                      rd_Issue_Memory_Pipeline, Mem_RF_Write_en, Load_Type_Issue[1],
                      Store_Type_Issue[1], Mem_Payload, Mem_Seq};
            a.older = Mem_Older;
            checks++;
            if (a !== t.e) begin
                errors++;
                $display("FAIL %s: got %h want %h", t.name, a, t.e);
            end
        end
    end

    initial begin
        ins_t a, b, l0, l1, r0, r1, r0z, x0, x1, st1, b0, b1, m0, m1, p0, p1, w0, w1, u;
        exp_t hold_e;

        rst = 1'b1;
        Stall_Issue_Branch_Pipeline = 1'b0;
        Stall_Issue_Memory_Pipeline = 1'b0;
        Flush_Dec = 1'b0;
        drive(nil, 1'b0, nil, 1'b0);
        step("reset", '0, 1'b0);
        rst = 1'b0;
        s = 8'd0;

        a = mk(CLS_ALU, 5'd1, 5'd2, 5'd5, 1'b1, 3'd0, 2'd0, 64'hA0);
        b = mk(CLS_MEM, 5'd6, 5'd0, 5'd8, 1'b1, 3'd2, 2'd0, 64'hB1);
        drive(a, 1'b1, b, 1'b1);
        step("alu_mem", E(P(a, s), P(b, s + 8'd1), 1'b0), 1'b1);
        s = s + 8'd2;
        drive(nil, 1'b0, nil, 1'b0);
        step("idle0", '0, 1'b1);

        l0 = mk(CLS_MEM, 5'd3, 5'd0, 5'd10, 1'b1, 3'd1, 2'd0, 64'hC0);
        l1 = mk(CLS_MEM, 5'd4, 5'd0, 5'd11, 1'b1, 3'd2, 2'd0, 64'hC1);
        drive(l0, 1'b1, l1, 1'b1);
        step("ld_ld_c1", E('0, P(l0, s), 1'b0), 1'b1);
        step("ld_ld_c2", E('0, P(l1, s + 8'd1), 1'b0), 1'b0);
        s = s + 8'd2;
        drive(nil, 1'b0, nil, 1'b0);
        step("idle1", '0, 1'b1);

        r0 = mk(CLS_ALU, 5'd1, 5'd1, 5'd7, 1'b1, 3'd0, 2'd0, 64'hD0);
        r1 = mk(CLS_ALU, 5'd2, 5'd7, 5'd9, 1'b1, 3'd0, 2'd0, 64'hD1);
        drive(r0, 1'b1, r1, 1'b1);
        step("raw_c1", E(P(r0, s), '0, 1'b0), 1'b1);
        step("raw_c2", E(P(r1, s + 8'd1), '0, 1'b0), 1'b0);
        s = s + 8'd2;
        r0z = r0;
        r0z.rd = 5'd0;
        r1.rs2 = 5'd0;
        drive(r0z, 1'b1, r1, 1'b1);
        step("raw_rd0", E(P(r0z, s), P(r1, s + 8'd1), 1'b0), 1'b1);
        s = s + 8'd2;

        x0 = mk(2'b11, 5'd3, 5'd4, 5'd12, 1'b1, 3'd0, 2'd0, 64'hE0);
        x1 = mk(CLS_BRANCH, 5'd5, 5'd6, 5'd0, 1'b0, 3'd0, 2'd0, 64'hE1);
        drive(x0, 1'b1, x1, 1'b1);
        step("rsv_br", E(P(x1, s + 8'd1), P(x0, s), 1'b1), 1'b1);
        s = s + 8'd2;

        st1 = mk(CLS_MEM, 5'd7, 5'd8, 5'd0, 1'b0, 3'd0, 2'd2, 64'hF1);
        drive(nil, 1'b0, st1, 1'b1);
        step("slot1_only", E('0, P(st1, s), 1'b0), 1'b1);
        s = s + 8'd1;

        b0 = mk(CLS_BRANCH, 5'd1, 5'd2, 5'd0, 1'b0, 3'd0, 2'd0, 64'h10);
        b1 = mk(CLS_BRANCH, 5'd3, 5'd4, 5'd0, 1'b0, 3'd0, 2'd0, 64'h11);
        drive(b0, 1'b1, b1, 1'b1);
        hold_e = E(P(b0, s), '0, 1'b0);
        step("br_br_c1", hold_e, 1'b1);
        drive(nil, 1'b0, nil, 1'b0);
        Stall_Issue_Memory_Pipeline = 1'b1;
        for (int k = 0; k < 3; k++) step("stall_hold", hold_e, 1'b0);
        Stall_Issue_Memory_Pipeline = 1'b0;
        step("stall_release", E(P(b1, s + 8'd1), '0, 1'b0), 1'b0);
        s = s + 8'd2;
        step("idle2", '0, 1'b1);

        m0 = mk(CLS_MEM, 5'd1, 5'd0, 5'd2, 1'b1, 3'd4, 2'd0, 64'h20);
        m1 = mk(CLS_MEM, 5'd2, 5'd0, 5'd3, 1'b1, 3'd5, 2'd0, 64'h21);
        drive(m0, 1'b1, m1, 1'b1);
        step("mem_mem_c1", E('0, P(m0, s), 1'b0), 1'b1);
        s = s + 8'd1;
        drive(nil, 1'b0, nil, 1'b0);
        Flush_Dec = 1'b1;
        Stall_Issue_Branch_Pipeline = 1'b1;
        step("flush", '0, 1'b0);
        Flush_Dec = 1'b0;
        Stall_Issue_Branch_Pipeline = 1'b0;
        step("after_flush", '0, 1'b1);
        drive(m1, 1'b1, nil, 1'b0);
        step("seq_kept", E('0, P(m1, s), 1'b0), 1'b1);
        s = s + 8'd1;

        for (int k = 0; k < 120; k++) begin
            p0 = mk(CLS_ALU, 5'd1, 5'd2, 5'd3, 1'b1, 3'd0, 2'd0, {56'h0, s});
            p1 = mk(CLS_ALU, 5'd4, 5'd5, 5'd6, 1'b1, 3'd0, 2'd0, {56'h1, s});
            drive(p0, 1'b1, p1, 1'b1);
            step("seq_run", E(P(p0, s), P(p1, s + 8'd1), 1'b0), 1'b1);
            s = s + 8'd2;
        end
        w0 = mk(CLS_ALU, 5'd9, 5'd10, 5'd11, 1'b1, 3'd0, 2'd0, 64'h30);
        w1 = mk(CLS_MEM, 5'd12, 5'd13, 5'd0, 1'b0, 3'd0, 2'd1, 64'h31);
        drive(w0, 1'b1, w1, 1'b1);
        step("seq_wrap", E(P(w0, 8'd255), P(w1, 8'd0), 1'b0), 1'b1);
        u = mk(CLS_ALU, 5'd14, 5'd15, 5'd16, 1'b1, 3'd0, 2'd0, 64'h40);
        drive(u, 1'b1, nil, 1'b0);
        step("seq_after_wrap", E(P(u, 8'd1), '0, 1'b0), 1'b1);

        drive(b0, 1'b1, b1, 1'b1);
        step("rst_pend_c1", E(P(b0, 8'd2), '0, 1'b0), 1'b1);
        rst = 1'b1;
        step("rst_pend", '0, 1'b0);
        rst = 1'b0;
        drive(nil, 1'b0, nil, 1'b0);
        step("after_rst", '0, 1'b1);
        drive(u, 1'b1, nil, 1'b0);
        step("seq_reset", E(P(u, 8'd0), '0, 1'b0), 1'b1);
        drive(nil, 1'b0, nil, 1'b0);
        step("idle3", '0, 1'b1);

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_dispatch_unit.md
Name: issue_dispatch_unit

Overview:
- Issue stage of the dual-issue core: accepts a decoded instruction pair from Decode and steers each instruction into the Branch or Memory pipeline issue register.
- Produces the per-pipeline issue fields (rs1/rs2/rd, write enable, Load/Store type) that the hazard unit reads.
- Obeys the hazard unit's Stall_Issue_* and Flush_Dec outputs.
- Splits structurally conflicting or intra-pair dependent pairs over two cycles, preserving program order.

Parameters:
- PAYLOAD_W, 64, opaque per-instruction payload (PC, immediate, ALU op) carried untouched.
- SEQ_W, 8, width of the issue sequence tag counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- Dec_Valid  in  2  slot valid bits; slot0 is older
- Dec_Class  in  2x2  per slot: 00 ALU, 01 BRANCH, 10 MEM, 11 reserved (treated as ALU)
- Dec_rs1, Dec_rs2, Dec_rd  in  2x5  register indices per slot
- Dec_RF_Write_en  in  2  per-slot register-file write enable
- Dec_Load_Type  in  2x3  per slot
- Dec_Store_Type  in  2x2  per slot
- Dec_Payload  in  2xPAYLOAD_W  per slot
- Dec_Ready  out  1  pair is accepted on a cycle where Dec_Ready=1
- Stall_Issue_Branch_Pipeline  in  1  from hazard unit
- Stall_Issue_Memory_Pipeline  in  1  from hazard unit
- Flush_Dec  in  1  mispredict flush
- Br_Valid, Mem_Valid  out  1 each  issue-register valid
- rs1/rs2/rd_Issue_Branch_Pipeline, rs1/rs2/rd_Issue_Memory_Pipeline  out  5 each
- Br_RF_Write_en, Mem_RF_Write_en  out  1 each
- Load_Type_Issue  out  2x3, Store_Type_Issue  out  2x2  index 0 Branch pipe, index 1 Memory pipe
- Br_Payload, Mem_Payload  out  PAYLOAD_W each
- Br_Seq, Mem_Seq  out  SEQ_W each  program-order tag
- Mem_Older  out  1  1 when both valid and the Memory slot holds the older instruction

Behaviour:
- Reset (rst=1 at posedge): all valids 0, all fields 0, Seq counter 0, FSM ACCEPT, Dec_Ready 0 during reset.
- Hold: Hold = Stall_Issue_Branch_Pipeline | Stall_Issue_Memory_Pipeline. While Hold is asserted, all issue registers, the pending register and the FSM keep their values, and Dec_Ready=0.
- Flush: Flush_Dec has priority over Hold. The next cycle has all valids 0, the pending entry dropped, the FSM in ACCEPT, and the Seq counter unchanged.
- Dec_Ready: Dec_Ready = (state==ACCEPT) & ~Hold & ~Flush_Dec & ~rst. It is combinational from the state and inputs.
- Split condition (both slots valid), any of:
  - both slots MEM;
  - both slots BRANCH;
  - slot1 rs1 or rs2 equals slot0 rd, with slot0 write enable set and rd != 0.
- Steering, pair not split:
  - BRANCH goes to the Branch pipe; MEM goes to the Memory pipe.
  - ALU takes whichever pipe is left.
  - ALU+ALU: slot0 to Branch, slot1 to Memory.
- Single valid slot: MEM goes to Memory; otherwise the instruction goes to Branch.
- Split pairs:
  - Slot0 issues alone per the single-slot rule.
  - Slot1 is latched into the pending register and the FSM moves to PENDING.
- PENDING, not held: the pending instruction issues alone per the single-slot rule and the FSM moves to ACCEPT. A new pair is not accepted in the same cycle; latency cost is one bubble cycle.
- Empty issue cycles: an unused pipe, or a cycle with nothing issued, drives valid 0 and zero fields. A stale rd must not reach the hazard unit.
- Seq tags:
  - Each issued instruction takes the current counter value, older first.
  - The counter advances by the number issued (0..2) and wraps modulo 2^SEQ_W.
- Mem_Older: 1 only when both valids are 1 and the Memory slot came from slot0.
- Latency: an accepted pair appears in the issue registers on the next posedge.
- Reserved class 11 decodes as ALU; no error output.

Decomposition:
- The shared package (Header_File.svh) holds:
  - the class encoding constants CLS_ALU, CLS_BRANCH, CLS_MEM;
  - a packed struct issue_slot_t {rs1, rs2, rd, we, load_type, store_type, payload};
  - the FSM enum {ACCEPT, PENDING}.
- One natural sub-module, issue_steer: pure combinational logic that turns a pair of classes and valids into split and pipe-select signals. It is reused for the pending/single-slot case.

Test Plan:
- ALU (rd=5) + MEM load (rs1=6), no hazards → next cycle:
  - Br_Valid=1, rd_Issue_Branch_Pipeline=5;
  - Mem_Valid=1, Load_Type_Issue[1] matches input;
  - Mem_Older=0, Seq 0/1.
- Two loads → cycle1 Memory slot holds slot0 with Br_Valid=0; cycle2 Memory slot holds slot1; Dec_Ready is low for the cycle in PENDING.
- Intra-pair RAW: slot0 writes x7, slot1 reads rs2=7 → split over two cycles. Repeat with rd=0 → no split.
- Stall_Issue_Memory_Pipeline high for 3 cycles while in PENDING → outputs frozen 3 cycles, Dec_Ready=0, then the pending instruction issues.
- Flush_Dec together with a stall, while in PENDING → next cycle all valids 0, state ACCEPT, pending instruction never issued.
- Seq counter at 255 with a pair issued → tags 255 and 0, then the counter reads 1; rst mid-PENDING → all outputs zero next cycle.
